mem_latency_responder: RTL

MEM_LATENCY_RESPONDER -- requirements
Module: mem_latency_responder

---
 rtl/mem_latency_responder.sv | 95 +++++++++
 1 files changed

// File: rtl/mem_latency_responder.sv
// mem_latency_responder: line memory answering each request after a fixed LATENCY.
// Define MEM_BOUNDS_CHECK_EN to flag out-of-range addresses with mem_err instead of wrapping.
module mem_latency_responder #(
   parameter int WIDTH   = 128,
   parameter int ADDR_W  = 32,
   parameter int DEPTH   = 64,
   parameter int LATENCY = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_enable,
   input  logic              mem_rw,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [WIDTH-1:0]  mem_data_in,
   output logic [WIDTH-1:0]  mem_data_out,
   output logic              mem_ack,
   output logic              mem_err
);
   localparam int OFF = $clog2(WIDTH / 8);
   localparam int IW  = $clog2(DEPTH);
   localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, ACK, WAIT_LOW} state_t;

   state_t           state, state_n;
   logic [CW-1:0]    cnt;
   logic             rw_q;
   logic [IW-1:0]    idx_q;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             sample, commit, c_rw, c_oor;
   logic [IW-1:0]    c_idx;
   logic [WIDTH-1:0] c_data;
   logic             unused;

   assign unused  = ^mem_addr;
   assign sample  = (state == IDLE) && mem_enable;
   assign commit  = (state_n == ACK) && (state != ACK);
   assign mem_ack = (state == ACK);

   // with LATENCY=1 the commit edge is the sampling edge, so the live inputs are used
   assign c_rw   = sample ? mem_rw : rw_q;
   assign c_idx  = sample ? mem_addr[OFF +: IW] : idx_q;
   assign c_data = sample ? mem_data_in : data_q;

`ifdef MEM_BOUNDS_CHECK_EN
   logic oor_q, oor_in;
   assign oor_in = |(mem_addr >> (OFF + IW));
   assign c_oor  = sample ? oor_in : oor_q;
   always_ff @(posedge clk) begin
      if (reset)
         oor_q <= 1'b0;
      else if (sample)
         oor_q <= oor_in;
   end
`else
   assign c_oor = 1'b0;
`endif

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = !mem_enable ? IDLE : (LATENCY == 1) ? ACK : BUSY;
         BUSY:    state_n = !mem_enable ? IDLE : (cnt == '0) ? ACK : BUSY;
         ACK:     state_n = mem_enable ? WAIT_LOW : IDLE;
         default: state_n = mem_enable ? WAIT_LOW : IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         rw_q         <= 1'b0;
         idx_q        <= '0;
         data_q       <= '0;
         mem_data_out <= '0;
         mem_err      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         state   <= state_n;
         mem_err <= commit && c_oor;
         if (sample) begin
            rw_q   <= mem_rw;
            idx_q  <= mem_addr[OFF +: IW];
            data_q <= mem_data_in;
            cnt    <= CW'(LATENCY - 1);
         end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (commit && c_rw && !c_oor) mem[c_idx] <= c_data;
         if (commit && !c_rw) mem_data_out <= c_oor ? '0 : mem[c_idx];
      end
   end
endmodule
